// File: rtl/mdu_iterative_pkg.sv
// Shared constants and encodings for the iterative multiply/divide unit.
package mdu_iterative_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement negate of a W-bit value.
module mdu_sign_adjust #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + 1'b1) : val_i;

endmodule

// File: rtl/mdu_iterative.sv
// 32-cycle shift-add multiplier / restoring divider feeding HI/LO.
module mdu_iterative
    import mdu_iterative_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             HILO_EN,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             rsgn_q, rsgn_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, addend, shl, diff;
    logic               ge;
    logic [WIDTH-1:0]   it_acc, it_mq;
    logic [2*WIDTH-1:0] prod_adj;
    logic [WIDTH-1:0]   quo_adj, rem_adj;

    mdu_sign_adjust #(.W(WIDTH)) u_mag_a (
        .neg_i (op_is_signed(OP) & A[WIDTH-1]),
        .val_i (A),
        .val_o (a_mag)
    );

    mdu_sign_adjust #(.W(WIDTH)) u_mag_b (
        .neg_i (op_is_signed(OP) & B[WIDTH-1]),
        .val_i (B),
        .val_o (b_mag)
    );

    // One iteration of either algorithm on the {acc, mq} pair.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, b_q};
        addend = mq_q[0] ? sum : {1'b0, acc_q};
        shl    = {acc_q, mq_q[WIDTH-1]};
        diff   = shl - {1'b0, b_q};
        ge     = shl >= {1'b0, b_q};
        if (op_is_div(op_q)) begin
            it_acc = ge ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
            it_mq  = {mq_q[WIDTH-2:0], ge};
        end else begin
            it_acc = addend[WIDTH:1];
            it_mq  = {addend[0], mq_q[WIDTH-1:1]};
        end
    end

    mdu_sign_adjust #(.W(2*WIDTH)) u_prod (
        .neg_i (sgn_q),
        .val_i ({it_acc, it_mq}),
        .val_o (prod_adj)
    );

    mdu_sign_adjust #(.W(WIDTH)) u_quo (
        .neg_i (sgn_q),
        .val_i (it_mq),
        .val_o (quo_adj)
    );

    mdu_sign_adjust #(.W(WIDTH)) u_rem (
        .neg_i (rsgn_q),
        .val_i (it_acc),
        .val_o (rem_adj)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rsgn_d  = rsgn_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d    = OP;
                    acc_d   = '0;
                    mq_d    = a_mag;
                    b_d     = b_mag;
                    sgn_d   = op_is_signed(OP) & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rsgn_d  = op_is_signed(OP) & A[WIDTH-1];
                    dz_d    = (B == '0);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = it_acc;
                mq_d  = it_mq;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FINISH;
                    if (op_is_div(op_q)) begin
                        // A zero divisor leaves |A| as remainder; force all-ones quotient.
                        hi_d = rem_adj;
                        lo_d = dz_q ? '1 : quo_adj;
                    end else begin
                        {hi_d, lo_d} = prod_adj;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rsgn_q  <= rsgn_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = (state_q == ST_FINISH);
    assign HILO_EN = DONE;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: results, latency, START masking, reset.
module tb_mdu_iterative;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE, HILO_EN;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    mdu_iterative dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .START   (START),
        .OP      (OP),
        .A       (A),
        .B       (B),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .HILO_EN (HILO_EN),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t   e;
        longint p;
        logic [63:0] pu;
        int     sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                pu = {32'h0, a} * {32'h0, b};
                e.hi = pu[63:32];
                e.lo = pu[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    e.lo = 32'h80000000; e.hi = 32'h0;
                end else begin
                    e.lo = sa / sb; e.hi = sa % sb;
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFFFFFF; e.hi = a;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after FINISH.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit junk);
        exp_t e;
        int   n;
        bit   seen;
        START = 1'b1; OP = op; A = a; B = b;
        sb_q.push_back(model(op, a, b));
        n = 0;
        seen = 0;
        while (n < 40 && !seen) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (n == 1) begin
                START = 1'b0;
                A = $urandom; B = $urandom; OP = 2'($urandom_range(0, 3));
                chk("busy_after_start", 64'(BUSY), 64'd1);
            end
            if (junk && n == 10) START = 1'b1;
            if (junk && n == 11) START = 1'b0;
            if (DONE) seen = 1;
            else if (HILO_EN) chk("early_hilo_en", 64'(HILO_EN), 64'd0);
        end
        e = sb_q.pop_front();
        if (!seen) begin
            chk("done_timeout", 64'(n), 64'd33);
            return;
        end
        chk("latency", 64'(n), 64'd33);
        chk("hilo_en", 64'(HILO_EN), 64'd1);
        chk($sformatf("hi op%0d", op), 64'(HI), 64'(e.hi));
        chk($sformatf("lo op%0d", op), 64'(LO), 64'(e.lo));
        if (junk) begin
            START = 1'b1; A = 32'h5; B = 32'h3; OP = 2'b11;
        end
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        chk("done_one_cycle", {62'h0, DONE, BUSY}, 64'd0);
        if (junk) begin
            chk("hi_hold", 64'(HI), 64'(e.hi));
            chk("lo_hold", 64'(LO), 64'(e.lo));
        end
    endtask

    task automatic reset_mid_run(input logic [31:0] a, input logic [31:0] b);
        int pulses;
        exp_t e;
        START = 1'b1; OP = 2'b01; A = a; B = b;
        sb_q.push_back(model(2'b01, a, b));
        repeat (11) begin
            @(posedge CLK);
            @(negedge CLK);
            START = 1'b0;
        end
        #2 RST_N = 1'b0;
        #1;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        #1 RST_N = 1'b1;
        e = sb_q.pop_front();
        pulses = 0;
        repeat (40) begin
            @(negedge CLK);
            if (HILO_EN) pulses++;
        end
        chk("no_pulse_after_rst", 64'(pulses), 64'd0);
    endtask

    initial begin
        #12;
        chk("init_busy", 64'(BUSY), 64'd0);
        chk("init_done", {63'h0, DONE}, 64'd0);
        chk("init_hilo_en", 64'(HILO_EN), 64'd0);
        chk("init_hi_lo", {HI, LO}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        run_op(2'b11, 32'd7, 32'd2, 0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(2'b11, 32'h12345678, 32'h0, 0);
        run_op(2'b10, 32'hF0000001, 32'h0, 0);
        run_op(2'b10, 32'd100, 32'hFFFFFFF9, 1);
        run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 0);
        for (int i = 0; i < 8; i++)
            run_op(2'(i % 4), $urandom, (i == 6) ? 32'($urandom_range(1, 9)) : $urandom, 0);

        reset_mid_run(32'hDEADBEEF, 32'h1234);
        run_op(2'b01, 32'd6, 32'd7, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
